pico_csr_bank: RTL and testbench
================================

// Module: pico_csr_bank
// PURPOSE
//  Parametrised PicoRV32-native-bus CSR slave: N_RW byte-strobed RW words, N_RO read-only words,
//  a trigger word (1-cycle strobes), sticky W1C event status with interrupt enable and irq output.
//  Registered valid/ready handshake. Sits between the CPU bus decoder and a peripheral core.
// PARAMETERS
//  ADDR_W   8   byte-address width; word index = addr[ADDR_W-1:2], addr[1:0] ignored
//  N_RW     4   number of 32-bit RW registers (>=1)
//  N_RO     1   number of 32-bit RO registers (>=0)
//  N_TRIG   8   trigger bits (1..32)
//  N_EVT    8   event/status bits (1..32)
//  RST_VAL  0   32-bit reset value of every RW register
// PORTS
//  clk         in   1            clock, all logic on posedge
//  rst         in   1            synchronous reset, active-high
//  valid       in   1            bus request; held by master until ready
//  ready       out  1            1-cycle acknowledge
//  wstrb       in   4            byte enables; 0 = read
//  addr        in   ADDR_W       byte address
//  wdata       in   32           write data
//  rdata       out  32           read data, valid only while ready=1, else 0
//  rw_q        out  N_RW*32      RW register contents, word i at [32*i+:32]
//  ro_d        in   N_RO*32      RO register sources, sampled at request cycle
//  trig_pulse  out  N_TRIG       one-cycle strobes
//  evt_in      in   N_EVT        event set inputs, level-high sets status each cycle
//  irq         out  1            registered |(status & irq_en)
// BEHAVIOUR
//  Map (word idx k): RW k=0..N_RW-1; RO k=N_RW..N_RW+N_RO-1; TRIG=N_RW+N_RO; STATUS=+1; IRQ_EN=+2.
//  Unmapped idx: read 0, write dropped, still acknowledged.
//  FSM IDLE/ACK. IDLE & valid -> ACK (addr/wstrb/wdata/read value captured). ACK: ready=1 for
//   exactly one cycle, write commits on this cycle's edge, -> IDLE. Latency valid->ready = 1 cycle.
//   After ACK one IDLE cycle minimum; back-to-back requests give ready every 2nd cycle.
//  Writes: byte b updated iff wstrb[b]; applies to RW, IRQ_EN (bits >=N_EVT read 0), STATUS, TRIG.
//  TRIG: written bits with value 1 (masked by wstrb) assert trig_pulse the cycle after ready; reads 0.
//  STATUS: bit set when evt_in=1; write-1-to-clear; same-cycle set and clear -> set wins.
//  irq registered from status/irq_en: rises 1 cycle after status bit and enable both 1.
//  RO read returns ro_d value at the request (IDLE->ACK) cycle.
//  Reset: state IDLE, ready=0, rdata=0, rw_q=RST_VAL, status=0, irq_en=0, trig_pulse=0, irq=0.
//   Reset during ACK aborts: no write committed, ready low next cycle.
//  valid dropped in ACK: ack and commit still occur (master protocol violation, not checked).
// STRUCTURE
//  pico_csr_pkg: state_t {IDLE,ACK}; functions trig_idx/status_idx/irqen_idx(N_RW,N_RO);
//   byte_merge(old,wdata,wstrb).
//  Sub-module pico_csr_evt: sticky W1C status + irq_en + registered irq, parametrised on N_EVT.
// TESTING
//  1 reset: rst=1 two cycles -> ready=0, rw_q all RST_VAL, irq=0, trig_pulse=0.
//  2 write idx0 wdata=0xA5A5_1234 wstrb=0b0101 -> ready 1 cycle later; rw_q[31:0]=0x00A5_0034;
//    read idx0 -> rdata=0x00A5_0034 while ready=1.
//  3 ro_d=0xDEAD_BEEF, read idx N_RW -> 0xDEADBEEF; write idx N_RW -> ignored, ready asserted.
//  4 write TRIG=0x05 -> trig_pulse=0x05 one cycle after ready, 0 next; read TRIG -> 0.
//  5 evt_in[3] pulse, irq_en=0x08 -> status=0x08, irq=1 next cycle; W1C 0x08 same cycle as evt_in[3]=1
//    -> status stays 0x08; W1C alone -> status=0, irq=0 next cycle.
//  6 rst during ACK of write idx1 -> rw_q word1 unchanged; read addr 0xFC (unmapped) -> rdata=0.

Source files
------------

// File: rtl/pico_csr_pkg.sv
// rtl/pico_csr_pkg.sv - shared types and address-map helpers for the CSR bank
package pico_csr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  // Word index of the trigger register, placed right after the RO block
  function automatic int trig_idx(input int n_rw, input int n_ro);
    return n_rw + n_ro;
  endfunction

  function automatic int status_idx(input int n_rw, input int n_ro);
    return n_rw + n_ro + 1;
  endfunction

  function automatic int irqen_idx(input int n_rw, input int n_ro);
    return n_rw + n_ro + 2;
  endfunction

  // Replace only the bytes whose strobe is set
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pico_csr_evt.sv
// rtl/pico_csr_evt.sv - sticky W1C event status, interrupt enable and registered irq
module pico_csr_evt #(
  parameter int N_EVT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_EVT-1:0] evt_in,
  input  logic [N_EVT-1:0] clr_mask,
  input  logic             irqen_we,
  input  logic [N_EVT-1:0] irqen_wdata,
  output logic [N_EVT-1:0] status,
  output logic [N_EVT-1:0] irq_en,
  output logic             irq
);

  // Status bits: clear first, then set, so a coincident event is never lost
  always_ff @(posedge clk) begin
    if (rst) status <= '0;
    else     status <= (status & ~clr_mask) | evt_in;
  end

  // Interrupt enable mask, written as a whole after byte merging upstream
  always_ff @(posedge clk) begin
    if (rst)           irq_en <= '0;
    else if (irqen_we) irq_en <= irqen_wdata;
  end

  // irq follows the enabled status with one cycle of latency
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(status & irq_en);
  end

endmodule

// File: rtl/pico_csr_bank.sv
// rtl/pico_csr_bank.sv - PicoRV32 native-bus CSR slave with RW/RO/trigger/event registers
module pico_csr_bank #(
  parameter int          ADDR_W  = 8,
  parameter int          N_RW    = 4,
  parameter int          N_RO    = 1,
  parameter int          N_TRIG  = 8,
  parameter int          N_EVT   = 8,
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                valid,
  output logic                                ready,
  input  logic [3:0]                          wstrb,
  input  logic [ADDR_W-1:0]                   addr,
  input  logic [31:0]                         wdata,
  output logic [31:0]                         rdata,
  output logic [N_RW*32-1:0]                  rw_q,
  input  logic [((N_RO > 0) ? N_RO : 1)*32-1:0] ro_d,
  output logic [N_TRIG-1:0]                   trig_pulse,
  input  logic [N_EVT-1:0]                    evt_in,
  output logic                                irq
);
  import pico_csr_pkg::*;

  localparam logic [31:0] TRIG_K   = 32'(trig_idx(N_RW, N_RO));
  localparam logic [31:0] STATUS_K = 32'(status_idx(N_RW, N_RO));
  localparam logic [31:0] IRQEN_K  = 32'(irqen_idx(N_RW, N_RO));

  state_t           state_q, state_d;
  logic [31:0]      idx_in, idx_q;
  logic [3:0]       wstrb_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rd_val, rd_q;
  logic [31:0]      rw_r [N_RW];
  logic [N_EVT-1:0] status, irq_en;
  logic             commit;
  logic [31:0]      wbits, irqen_merged;
  logic [N_EVT-1:0] clr_mask;
  logic             irqen_we;
  logic             unused_bits;

  assign idx_in       = 32'(addr[ADDR_W-1:2]);
  assign commit       = (state_q == ACK) && (wstrb_q != 4'b0);
  assign wbits        = byte_merge(32'h0, wdata_q, wstrb_q);
  assign irqen_merged = byte_merge(32'(irq_en), wdata_q, wstrb_q);
  assign clr_mask     = (commit && idx_q == STATUS_K) ? wbits[N_EVT-1:0] : '0;
  assign irqen_we     = commit && (idx_q == IRQEN_K);
  assign rdata        = ready ? rd_q : 32'h0;
  assign unused_bits  = ^{addr[1:0], wbits, irqen_merged};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and acknowledge: ACK always lasts one cycle and returns to IDLE
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: if (valid) state_d = ACK;
      ACK: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read mux evaluated in the request cycle so RO sources are sampled there
  always_comb begin
    rd_val = 32'h0;
    for (int k = 0; k < N_RW; k++) begin
      if (idx_in == 32'(k)) rd_val = rw_r[k];
    end
    for (int j = 0; j < N_RO; j++) begin
      if (idx_in == 32'(N_RW + j)) rd_val = ro_d[32*j +: 32];
    end
    if (idx_in == STATUS_K) rd_val = 32'(status);
    if (idx_in == IRQEN_K)  rd_val = 32'(irq_en);
  end

  // Capture the request and its read value on the IDLE->ACK transition
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= 32'h0;
      wstrb_q <= 4'h0;
      wdata_q <= 32'h0;
      rd_q    <= 32'h0;
    end else if (state_q == IDLE && valid) begin
      idx_q   <= idx_in;
      wstrb_q <= wstrb;
      wdata_q <= wdata;
      rd_q    <= rd_val;
    end
  end

  // RW registers commit on the ACK edge; reset wins and aborts the write
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_RW; k++) begin
      if (rst)                                rw_r[k] <= RST_VAL;
      else if (commit && idx_q == 32'(k))     rw_r[k] <= byte_merge(rw_r[k], wdata_q, wstrb_q);
    end
  end

  // Trigger strobes live for exactly the cycle after the acknowledge
  always_ff @(posedge clk) begin
    if (rst)                             trig_pulse <= '0;
    else if (commit && idx_q == TRIG_K)  trig_pulse <= wbits[N_TRIG-1:0];
    else                                 trig_pulse <= '0;
  end

  for (genvar g = 0; g < N_RW; g++) begin : g_rw_out
    assign rw_q[32*g +: 32] = rw_r[g];
  end

  pico_csr_evt #(.N_EVT(N_EVT)) u_evt (
    .clk         (clk),
    .rst         (rst),
    .evt_in      (evt_in),
    .clr_mask    (clr_mask),
    .irqen_we    (irqen_we),
    .irqen_wdata (irqen_merged[N_EVT-1:0]),
    .status      (status),
    .irq_en      (irq_en),
    .irq         (irq)
  );

endmodule

// File: tb/tb_pico_csr_bank.sv
// tb/tb_pico_csr_bank.sv - randomized scoreboard bench for pico_csr_bank
module tb_pico_csr_bank;
  localparam int          ADDR_W   = 8;
  localparam int          N_RW     = 4;
  localparam int          N_RO     = 1;
  localparam int          N_TRIG   = 8;
  localparam int          N_EVT    = 8;
  localparam logic [31:0] RST_VAL  = 32'h1357_9BDF;
  localparam int          TRIG_K   = N_RW + N_RO;
  localparam int          STATUS_K = TRIG_K + 1;
  localparam int          IRQEN_K  = TRIG_K + 2;

  logic         clk = 1'b0;
  logic         rst, valid, ready, irq;
  logic [3:0]   wstrb;
  logic [7:0]   addr;
  logic [31:0]  wdata, rdata, ro_d;
  logic [127:0] rw_q;
  logic [7:0]   trig_pulse, evt_in;

  always #5 clk = ~clk;

  pico_csr_bank #(
    .ADDR_W(ADDR_W), .N_RW(N_RW), .N_RO(N_RO), .N_TRIG(N_TRIG), .N_EVT(N_EVT), .RST_VAL(RST_VAL)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rw_q(rw_q), .ro_d(ro_d), .trig_pulse(trig_pulse),
    .evt_in(evt_in), .irq(irq)
  );

  logic [31:0]  m_rw [N_RW];
  logic [7:0]   m_status, m_irqen, m_trig;
  logic         m_irq;
  logic [31:0]  exp_q [$];
  logic [127:0] erw;
  int           n_cmp = 0;
  int           n_mis = 0;
  bit           mon_en = 1'b0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
    return m;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int k;
    k = int'(a) / 4;
    if (k < N_RW)        return m_rw[k];
    if (k < N_RW + N_RO) return ro_d[32*(k-N_RW) +: 32];
    if (k == STATUS_K)   return 32'(m_status);
    if (k == IRQEN_K)    return 32'(m_irqen);
    return 32'h0;
  endfunction

  // Advance one clock edge and apply its effect to the reference model
  task automatic tick(input bit commit, input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
    int          k;
    logic [31:0] m;
    logic [7:0]  clr;
    logic        nirq;
    @(posedge clk);
    k    = int'(a) / 4;
    m    = bmask(s);
    clr  = 8'h0;
    nirq = |(m_status & m_irqen);
    if (rst) begin
      for (int i = 0; i < N_RW; i++) m_rw[i] = RST_VAL;
      m_status = 8'h0; m_irqen = 8'h0; m_trig = 8'h0; m_irq = 1'b0;
    end else begin
      m_irq  = nirq;
      m_trig = 8'h0;
      if (commit) begin
        if (k < N_RW)           m_rw[k] = (m_rw[k] & ~m) | (d & m);
        else if (k == TRIG_K)   m_trig  = 8'(d & m);
        else if (k == STATUS_K) clr     = 8'(d & m);
        else if (k == IRQEN_K)  m_irqen = 8'((32'(m_irqen) & ~m) | (d & m));
      end
      m_status = (m_status & ~clr) | evt_in;
    end
    #1;
  endtask

  task automatic idle(input logic [7:0] ev);
    evt_in = ev;
    tick(1'b0, 8'h0, 4'h0, 32'h0);
    evt_in = 8'h0;
  endtask

  // One bus transaction: request cycle, ACK cycle; optional reset during ACK
  task automatic bus(input logic [7:0] a, input logic [3:0] s, input logic [31:0] d,
                     input logic [7:0] ev0, input logic [7:0] ev1, input bit abort);
    logic [31:0] e;
    valid = 1'b1; addr = a; wstrb = s; wdata = d; evt_in = ev0;
    e = model_read(a);
    tick(1'b0, a, s, d);
    exp_q.push_back(e);
    evt_in = ev1;
    if (abort) rst = 1'b1;
    tick(1'b1, a, s, d);
    valid = 1'b0; wstrb = 4'h0; evt_in = 8'h0; rst = 1'b0;
  endtask

  // Monitor: ready only when a response is owed, rdata and outputs against model
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready", 128'(ready), 128'(exp_q.size() != 0));
      if (ready && exp_q.size() != 0) chk("rdata", 128'(rdata), 128'(exp_q.pop_front()));
      else if (!ready)                chk("rdata_idle", 128'(rdata), 128'h0);
      for (int k = 0; k < N_RW; k++) erw[32*k +: 32] = m_rw[k];
      chk("rw_q", rw_q, erw);
      chk("trig_pulse", 128'(trig_pulse), 128'(m_trig));
      chk("irq", 128'(irq), 128'(m_irq));
    end
  end

  initial begin
    rst = 1'b1; valid = 1'b0; wstrb = 4'h0; addr = 8'h0; wdata = 32'h0; ro_d = 32'h0; evt_in = 8'h0;
    tick(1'b0, 8'h0, 4'h0, 32'h0);
    tick(1'b0, 8'h0, 4'h0, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_ready", 128'(ready), 128'h0);
    chk("rst_rw_q", rw_q, {4{RST_VAL}});
    chk("rst_irq", 128'(irq), 128'h0);
    chk("rst_trig", 128'(trig_pulse), 128'h0);

    bus(8'h00, 4'hF, 32'h0, 8'h0, 8'h0, 1'b0);
    bus(8'h00, 4'h5, 32'hA5A5_1234, 8'h0, 8'h0, 1'b0);
    chk("t2_rw0", 128'(rw_q[31:0]), 128'h00A5_0034);
    bus(8'h03, 4'h0, 32'h0, 8'h0, 8'h0, 1'b0);

    ro_d = 32'hDEAD_BEEF;
    bus(8'(N_RW * 4), 4'h0, 32'h0, 8'h0, 8'h0, 1'b0);
    bus(8'(N_RW * 4), 4'hF, 32'h1234_5678, 8'h0, 8'h0, 1'b0);

    bus(8'(TRIG_K * 4), 4'h1, 32'h0000_0005, 8'h0, 8'h0, 1'b0);
    chk("t4_trig", 128'(trig_pulse), 128'h05);
    idle(8'h0);
    chk("t4_trig_clr", 128'(trig_pulse), 128'h0);
    bus(8'(TRIG_K * 4), 4'h0, 32'h0, 8'h0, 8'h0, 1'b0);

    bus(8'(IRQEN_K * 4), 4'hF, 32'h0000_0008, 8'h0, 8'h0, 1'b0);
    idle(8'h08);
    idle(8'h0);
    chk("t5_irq_set", 128'(irq), 128'h1);
    bus(8'(STATUS_K * 4), 4'hF, 32'h0000_0008, 8'h0, 8'h08, 1'b0);
    bus(8'(STATUS_K * 4), 4'h0, 32'h0, 8'h0, 8'h0, 1'b0);
    bus(8'(STATUS_K * 4), 4'h1, 32'h0000_0008, 8'h0, 8'h0, 1'b0);
    idle(8'h0);
    chk("t5_irq_clr", 128'(irq), 128'h0);

    bus(8'h04, 4'hF, 32'hCAFE_F00D, 8'h0, 8'h0, 1'b1);
    chk("t6_word1", 128'(rw_q[63:32]), 128'(RST_VAL));
    bus(8'hFC, 4'h0, 32'h0, 8'h0, 8'h0, 1'b0);
    bus(8'hFC, 4'hF, 32'hFFFF_FFFF, 8'h0, 8'h0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [7:0]  a, ev0, ev1;
      logic [3:0]  s;
      logic [31:0] d;
      bit          ab;
      a   = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, IRQEN_K * 4 + 3)) : 8'($urandom);
      s   = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
      d   = $urandom;
      ev0 = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h0;
      ev1 = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h0;
      ab  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) ro_d = $urandom;
      bus(a, s, d, ev0, ev1, ab);
      if ($urandom_range(0, 2) == 0) idle(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0);
    end

    idle(8'h0);
    idle(8'h0);
    chk("queue_empty", 128'(exp_q.size()), 128'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
